fwd_hazard_unit: RTL
====================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter regAddrBits, default 5, SHALL set the register-address width for all rd/rs ports.
REQ-002 Parameter cntBits, default 16, SHALL set the stall-counter width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 id_valid  input  1  SHALL mark a real instruction in ID.
REQ-006 id_rs1, id_rs2  input  regAddrBits  SHALL be the ID-stage source registers.
REQ-007 id_rd  input  regAddrBits  SHALL be the ID-stage destination register.
REQ-008 id_regWrite, id_memRead  input  1  SHALL be the ID-stage writes-register and is-load flags.
REQ-009 branch_taken  input  1  SHALL be the EX-stage taken-branch/jump indication.
REQ-010 forwardA, forwardB  output  2  SHALL be the EX operand select lines for the two 3x1 operand muxes: 00 register file, 01 EX/MEM result, 10 MEM/WB result.
REQ-011 pc_stall, ifid_stall  output  1  SHALL hold the PC and IF/ID registers.
REQ-012 ifid_flush, idex_flush  output  1  SHALL bubble the IF/ID and ID/EX registers.
REQ-013 stall_count  output  cntBits  SHALL count load-use stall cycles.

Function
REQ-014 The unit SHALL keep shadow stages EX{valid,rs1,rs2,rd,regWrite,memRead}, MEM{valid,rd,regWrite}, WB{valid,rd,regWrite}, advancing each clk: MEM<=EX, WB<=MEM.
REQ-015 EX SHALL load the ID fields when neither stall nor flush is active; otherwise EX SHALL load a bubble (valid=0, all flags 0).
REQ-016 Load-use stall SHALL be combinational: EX.valid & EX.memRead & EX.rd!=0 & id_valid & (EX.rd==id_rs1 | EX.rd==id_rs2).
REQ-017 On stall: pc_stall=ifid_stall=1, idex_flush=1, ifid_flush=0; exactly one bubble per load-use pair.
REQ-018 On branch_taken: ifid_flush=idex_flush=1, pc_stall=ifid_stall=0; branch_taken SHALL override stall in the same cycle.
REQ-019 forwardA SHALL be 01 if MEM.valid & MEM.regWrite & MEM.rd!=0 & MEM.rd==EX.rs1; else 10 if the same WB test holds; else 00. forwardB identical for EX.rs2.
REQ-020 EX/MEM SHALL take priority over MEM/WB when both match.
REQ-021 Register 0 SHALL never be forwarded or trigger a stall.
REQ-022 forwardA/B SHALL be 00 whenever EX.valid=0; encoding 11 SHALL never be driven.
REQ-023 stall_count SHALL increment by 1 per cycle with stall=1 and branch_taken=0, saturating at all-ones.
REQ-024 Control FSM SHALL have states RUN and BUBBLE: RUN->BUBBLE on stall (without branch_taken); BUBBLE->RUN unconditionally next cycle; a stall raised in BUBBLE SHALL be a protocol error and asserted against in simulation.

Reset
REQ-025 On reset all shadow-stage valid and flag bits SHALL clear to 0, rd/rs fields to 0, FSM to RUN, stall_count to 0.
REQ-026 During reset and the first cycle after, forwardA=forwardB=00 and all stall/flush outputs SHALL be 0.
REQ-027 Reset asserted mid-stall SHALL discard the bubble; no stall SHALL carry over.

Structure
REQ-028 Forward-select encodings (FWD_RF=00, FWD_EXMEM=01, FWD_MEMWB=10) and FSM state codes SHALL live in the shared processor package used by the muxes.
REQ-029 A sub-module fwd_select SHALL compute one 2-bit select from (rs, MEM fields, WB fields), instantiated twice.
REQ-030 Implementation SHALL be single-clock, with no latches.

Verification
REQ-031 add x5 then sub x6,x5,x1 back-to-back -> cycle sub in EX: forwardA=01, no stall.
REQ-032 add x5; nop; or x7,x1,x5 -> or in EX: forwardB=10.
REQ-033 lw x5 then add x6,x5,x5 -> one cycle pc_stall=ifid_stall=idex_flush=1, stall_count 0->1, next cycle forwardA=forwardB=10.
REQ-034 add x0,x1,x2 then sub x3,x0,x0 -> forwardA=forwardB=00, no stall.
REQ-035 lw x5 / add x6,x5,x1 with branch_taken=1 same cycle -> ifid_flush=idex_flush=1, pc_stall=0, stall_count unchanged.
REQ-036 Reset pulsed during BUBBLE -> next cycle all outputs 0, stall_count=0, FSM=RUN.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared processor package for the forwarding / hazard unit.
// Holds the EX operand-mux select encodings and the control FSM state codes.
package fwd_hazard_unit_pkg;

  // Select codes for the two 3x1 EX operand muxes; 2'b11 is never driven.
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/fwd_hazard_unit_fwd_select.sv
// fwd_select: computes one EX operand forward select.
// Ports:
//   ex_valid                           - EX shadow stage holds a real instruction
//   rs                                 - EX source register being resolved
//   mem_valid, mem_reg_write, mem_rd   - MEM shadow stage producer
//   wb_valid, wb_reg_write, wb_rd      - WB shadow stage producer
//   sel                                - FWD_RF / FWD_EXMEM / FWD_MEMWB
module fwd_select
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned regAddrBits = 5
) (
  input  logic                   ex_valid,
  input  logic [regAddrBits-1:0] rs,
  input  logic                   mem_valid,
  input  logic                   mem_reg_write,
  input  logic [regAddrBits-1:0] mem_rd,
  input  logic                   wb_valid,
  input  logic                   wb_reg_write,
  input  logic [regAddrBits-1:0] wb_rd,
  output fwd_sel_e               sel
);

  logic mem_hit;
  logic wb_hit;

  // x0 is hardwired zero, so a write to it is never a forwarding source.
  assign mem_hit = mem_valid & mem_reg_write & (mem_rd != '0) & (mem_rd == rs);
  assign wb_hit  = wb_valid  & wb_reg_write  & (wb_rd  != '0) & (wb_rd  == rs);

  // The MEM producer is younger, so it wins over WB.
  always_comb begin
    sel = FWD_RF;
    if (ex_valid) begin
      if (mem_hit)     sel = FWD_EXMEM;
      else if (wb_hit) sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: data-forwarding and load-use hazard control for a
// 5-stage pipeline. Keeps shadow copies of the EX/MEM/WB register fields.
// Ports:
//   clk, reset (sync, active-high)
//   id_valid, id_rs1, id_rs2, id_rd, id_regWrite, id_memRead - ID instruction
//   branch_taken             - EX redirect, overrides any stall
//   forwardA, forwardB       - EX operand mux selects
//   pc_stall, ifid_stall     - hold PC and IF/ID
//   ifid_flush, idex_flush   - bubble IF/ID and ID/EX
//   stall_count              - saturating count of load-use stall cycles
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned regAddrBits = 5,
  parameter int unsigned cntBits     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [regAddrBits-1:0] id_rs1,
  input  logic [regAddrBits-1:0] id_rs2,
  input  logic [regAddrBits-1:0] id_rd,
  input  logic                   id_regWrite,
  input  logic                   id_memRead,
  input  logic                   branch_taken,
  output logic [1:0]             forwardA,
  output logic [1:0]             forwardB,
  output logic                   pc_stall,
  output logic                   ifid_stall,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic [cntBits-1:0]     stall_count
);

  logic                   ex_valid, ex_reg_write, ex_mem_read;
  logic [regAddrBits-1:0] ex_rs1, ex_rs2, ex_rd;
  logic                   mem_valid, mem_reg_write;
  logic [regAddrBits-1:0] mem_rd;
  logic                   wb_valid, wb_reg_write;
  logic [regAddrBits-1:0] wb_rd;

  ctrl_state_e state, state_next;
  logic        load_use;
  logic        stall;
  fwd_sel_e    sel_a, sel_b;

  assign load_use = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  // Stall only from RUN so each load-use pair yields exactly one bubble;
  // a taken branch squashes the dependent instruction instead.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    case (state)
      RUN:     if (load_use && !branch_taken) state_next = BUBBLE;
      BUBBLE:  state_next = RUN;
      default: state_next = RUN;
    endcase
    if (!reset) begin
      if (branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use && state == RUN) begin
        stall      = 1'b1;
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      stall_count   <= '0;
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_rd        <= '0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= '0;
    end else begin
      state         <= state_next;
      mem_valid     <= ex_valid;
      mem_reg_write <= ex_reg_write;
      mem_rd        <= ex_rd;
      wb_valid      <= mem_valid;
      wb_reg_write  <= mem_reg_write;
      wb_rd         <= mem_rd;
      if (idex_flush) begin
        ex_valid     <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
        ex_rs1       <= '0;
        ex_rs2       <= '0;
        ex_rd        <= '0;
      end else begin
        ex_valid     <= id_valid;
        ex_reg_write <= id_regWrite;
        ex_mem_read  <= id_memRead;
        ex_rs1       <= id_rs1;
        ex_rs2       <= id_rs2;
        ex_rd        <= id_rd;
      end
      if (stall && stall_count != '1) stall_count <= stall_count + cntBits'(1);
    end
  end

  fwd_select #(.regAddrBits(regAddrBits)) u_fwd_a (
    .ex_valid      (ex_valid),
    .rs            (ex_rs1),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .sel           (sel_a)
  );

  fwd_select #(.regAddrBits(regAddrBits)) u_fwd_b (
    .ex_valid      (ex_valid),
    .rs            (ex_rs2),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .sel           (sel_b)
  );

  assign forwardA = reset ? FWD_RF : sel_a;
  assign forwardB = reset ? FWD_RF : sel_b;

  // EX always holds a bubble while in BUBBLE, so a load-use there is a bug.
  a_no_stall_in_bubble: assert property (@(posedge clk) disable iff (reset)
    !(state == BUBBLE && load_use));

endmodule
